current_clarke_pairing: RTL
===========================

Name: current_clarke_pairing

Overview:
- Downstream stage of the two-channel current-detect path.
- Pairs the independent per-unit phase-A and phase-B current samples. Each channel's done pulse can arrive in a different cycle.
- Computes the Clarke transform from each pair: i_alpha = ia, i_beta = (ia + 2*ib)/sqrt3.
- Presents alpha/beta with a single-cycle valid strobe to the FOC current loop, and flags unpaired or overrun samples.

Parameters:
- DATA_WIDTH, 16: width of current samples and outputs, signed Q1.15 per-unit.
- PAIR_TIMEOUT, 1000: sys_clk cycles allowed between the first and second channel sample of a pair.
- INV_SQRT3, 18919: 1/sqrt3 in Q1.15.

Ports:
- sys_clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- detect_enable_in  input  1  pairing enable. Low forces IDLE.
- phase_a_current_in  input  DATA_WIDTH  signed per-unit phase-A current.
- phase_a_valid_in  input  1  one-cycle strobe qualifying phase_a_current_in.
- phase_b_current_in  input  DATA_WIDTH  signed per-unit phase-B current.
- phase_b_valid_in  input  1  one-cycle strobe qualifying phase_b_current_in.
- current_alpha_out  output  DATA_WIDTH  signed i_alpha, held until next result.
- current_beta_out  output  DATA_WIDTH  signed i_beta, held until next result.
- clarke_valid_out  output  1  one-cycle strobe: new alpha/beta.
- pair_timeout_err_out  output  1  one-cycle strobe: partial pair discarded on timeout.
- overrun_err_out  output  1  one-cycle strobe: sample dropped because the block was busy.
- busy_out  output  1  high in CALC states.

Behaviour:
- Reset (synchronous, sampled on sys_clk) gives:
  - state IDLE;
  - all outputs 0;
  - captured samples 0;
  - timeout counter 0.
  - Reset asserted mid-operation abandons the pair/calc with no valid or error strobe.
- States: IDLE, WAIT_B (A held), WAIT_A (B held), CALC1, CALC2, CALC3.
- IDLE:
  - a_valid only: capture A, go to WAIT_B, counter=1.
  - b_valid only: capture B, go to WAIT_A, counter=1.
  - Both in the same cycle: capture both, go to CALC1.
- WAIT_B / WAIT_A:
  - The missing channel's valid captures it and moves to CALC1.
  - A repeat valid on the already-held channel overwrites the held value. The counter is not restarted and no error is raised.
  - If counter reaches PAIR_TIMEOUT with the pair incomplete, pulse pair_timeout_err_out, discard, go to IDLE.
  - If the missing valid arrives in the same cycle the counter reaches PAIR_TIMEOUT, pairing wins and there is no error.
- CALC1: sum = ia + 2*ib, sign-extended to DATA_WIDTH+2 bits.
- CALC2: prod = sum * INV_SQRT3, full-precision signed product of 2*DATA_WIDTH+2 bits, registered.
- CALC3:
  - beta = (prod + 2^14) >>> 15 (arithmetic shift, round half up), saturated to [-2^(DW-1), 2^(DW-1)-1].
  - alpha = ia.
  - Register both outputs, pulse clarke_valid_out, return to IDLE.
- Latency: clarke_valid_out asserts exactly 3 cycles after the cycle in which the pair completes.
- Any a/b valid seen in CALC1..CALC3 is dropped and pulses overrun_err_out in the next cycle; the calculation is unaffected.
- A valid seen in the same cycle CALC3 returns to IDLE is dropped, not captured.
- detect_enable_in low: go to IDLE next cycle, ignore valids, no error strobes, outputs hold their last values.
- Error strobes and clarke_valid_out are never asserted for more than one consecutive cycle per event.

Test Plan:
- a=0x2000 and b=0x1000 valid in the same cycle -> 3 cycles later clarke_valid_out=1, alpha=0x2000, beta=0x24F4.
- a=0x7FFF, then b=0x7FFF 5 cycles later -> valid 3 cycles after the b strobe, alpha=0x7FFF, beta=0x7FFF (saturated). Repeat with 0x8000/0x8000 -> beta=0x8000.
- a=0x1000 only, PAIR_TIMEOUT=1000 -> pair_timeout_err_out pulse 1000 cycles after capture, no clarke_valid_out. A later b-then-a pair still computes correctly.
- Pair completes, then a_valid one cycle later (during CALC) -> overrun_err_out pulse, result unchanged. Then a=0,b=0 pair -> beta=0x0000.
- Reset asserted in WAIT_B, and separately in CALC2 -> all outputs 0 next cycle, no strobes.
- detect_enable_in low with valids toggling -> no strobes, outputs hold.

Source files
------------

// File: rtl/current_clarke_pairing.sv
// Pairs independent phase-A/B current samples and produces Clarke alpha/beta.
// Three-stage calc: sum, product by 1/sqrt3, round+saturate.
module current_clarke_pairing #(
    parameter int DATA_WIDTH   = 16,
    parameter int PAIR_TIMEOUT = 1000,
    parameter int INV_SQRT3    = 18919
) (
    input  logic                  sys_clk,
    input  logic                  reset,
    input  logic                  detect_enable_in,
    input  logic [DATA_WIDTH-1:0] phase_a_current_in,
    input  logic                  phase_a_valid_in,
    input  logic [DATA_WIDTH-1:0] phase_b_current_in,
    input  logic                  phase_b_valid_in,
    output logic [DATA_WIDTH-1:0] current_alpha_out,
    output logic [DATA_WIDTH-1:0] current_beta_out,
    output logic                  clarke_valid_out,
    output logic                  pair_timeout_err_out,
    output logic                  overrun_err_out,
    output logic                  busy_out
);

    localparam int SW = DATA_WIDTH + 2;
    localparam int PW = 2 * DATA_WIDTH + 2;
    localparam int CW = $clog2(PAIR_TIMEOUT + 1);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] WAIT_B = 3'd1;
    localparam logic [2:0] WAIT_A = 3'd2;
    localparam logic [2:0] CALC1  = 3'd3;
    localparam logic [2:0] CALC2  = 3'd4;
    localparam logic [2:0] CALC3  = 3'd5;

    localparam logic signed [PW-1:0] K_INV  = PW'(INV_SQRT3);
    localparam logic signed [PW-1:0] HALF   = PW'(2 ** 14);
    localparam logic signed [PW-1:0] MAXV   = PW'((2 ** (DATA_WIDTH - 1)) - 1);
    localparam logic signed [PW-1:0] MINV   = ~MAXV;
    localparam logic [CW-1:0]        CNT_TO = CW'(PAIR_TIMEOUT);

    logic [2:0]                   state;
    logic signed [DATA_WIDTH-1:0] ia_q;
    logic signed [DATA_WIDTH-1:0] ib_q;
    logic signed [SW-1:0]         sum_q;
    logic signed [PW-1:0]         prod_q;
    logic [CW-1:0]                cnt;

    logic signed [SW-1:0]         sum_c;
    logic signed [PW-1:0]         sum_w;
    logic signed [PW-1:0]         prod_c;
    logic signed [PW-1:0]         rnd_c;
    logic signed [PW-1:0]         shr_c;
    logic [DATA_WIDTH-1:0]        beta_c;

    assign sum_c  = {{2{ia_q[DATA_WIDTH-1]}}, ia_q}
                  + {ib_q[DATA_WIDTH-1], ib_q, 1'b0};
    assign sum_w  = {{(PW-SW){sum_q[SW-1]}}, sum_q};
    assign prod_c = sum_w * K_INV;
    assign rnd_c  = prod_q + HALF;
    assign shr_c  = rnd_c >>> 15;

    always_comb begin
        beta_c = shr_c[DATA_WIDTH-1:0];
        if (shr_c > MAXV)
            beta_c = MAXV[DATA_WIDTH-1:0];
        else if (shr_c < MINV)
            beta_c = MINV[DATA_WIDTH-1:0];
    end

    assign busy_out = (state == CALC1) || (state == CALC2) || (state == CALC3);

    always_ff @(posedge sys_clk) begin
        if (reset) begin
            state                <= IDLE;
            ia_q                 <= '0;
            ib_q                 <= '0;
            sum_q                <= '0;
            prod_q               <= '0;
            cnt                  <= '0;
            current_alpha_out    <= '0;
            current_beta_out     <= '0;
            clarke_valid_out     <= 1'b0;
            pair_timeout_err_out <= 1'b0;
            overrun_err_out      <= 1'b0;
        end else begin
            clarke_valid_out     <= 1'b0;
            pair_timeout_err_out <= 1'b0;
            overrun_err_out      <= 1'b0;
            if (!detect_enable_in) begin
                state <= IDLE;
                cnt   <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        if (phase_a_valid_in) ia_q <= phase_a_current_in;
                        if (phase_b_valid_in) ib_q <= phase_b_current_in;
                        if (phase_a_valid_in && phase_b_valid_in) begin
                            state <= CALC1;
                        end else if (phase_a_valid_in) begin
                            state <= WAIT_B;
                            cnt   <= CW'(1);
                        end else if (phase_b_valid_in) begin
                            state <= WAIT_A;
                            cnt   <= CW'(1);
                        end
                    end
                    WAIT_B, WAIT_A: begin
                        // Repeats on the held channel overwrite it; the timer keeps running.
                        if (phase_a_valid_in) ia_q <= phase_a_current_in;
                        if (phase_b_valid_in) ib_q <= phase_b_current_in;
                        if ((state == WAIT_B) ? phase_b_valid_in : phase_a_valid_in) begin
                            state <= CALC1;
                            cnt   <= '0;
                        end else if (cnt >= CNT_TO) begin
                            pair_timeout_err_out <= 1'b1;
                            state                <= IDLE;
                            cnt                  <= '0;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    CALC1: begin
                        overrun_err_out <= phase_a_valid_in | phase_b_valid_in;
                        sum_q           <= sum_c;
                        state           <= CALC2;
                    end
                    CALC2: begin
                        overrun_err_out <= phase_a_valid_in | phase_b_valid_in;
                        prod_q          <= prod_c;
                        state           <= CALC3;
                    end
                    CALC3: begin
                        overrun_err_out   <= phase_a_valid_in | phase_b_valid_in;
                        current_alpha_out <= ia_q;
                        current_beta_out  <= beta_c;
                        clarke_valid_out  <= 1'b1;
                        state             <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule
